// File: rtl/uart_frame_sequencer.sv
// Purpose: gathers UART characters into a coprocessor input frame, issues it, waits
//          (bounded) for the result, then streams the result bytes to the UART transmitter.
// Latency: cp_din_valid one cycle after the last rx_valid; tx_send one cycle after result capture.
// Backpressure: tx_busy stalls byte sends; rx_valid outside COLLECT is dropped and flagged.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   rx_byte / rx_valid          received character strobe
//   cp_din / cp_din_valid       assembled frame and its one-cycle issue pulse
//   cp_dout / cp_dout_valid     coprocessor result and its one-cycle pulse
//   tx_byte / tx_send / tx_busy transmitter byte, trigger and busy status
//   manual_req                  level request; a rising edge while idle replays the last result
//   busy, timeout_err, rx_overrun   status (error flags are sticky until reset)
module uart_frame_sequencer #(
    parameter int DBITS     = 8,
    parameter int FRAME_IN  = 4,
    parameter int FRAME_OUT = 4,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DBITS-1:0]           rx_byte,
    input  logic                       rx_valid,
    output logic [FRAME_IN*DBITS-1:0]  cp_din,
    output logic                       cp_din_valid,
    input  logic [FRAME_OUT*DBITS-1:0] cp_dout,
    input  logic                       cp_dout_valid,
    output logic [DBITS-1:0]           tx_byte,
    output logic                       tx_send,
    input  logic                       tx_busy,
    input  logic                       manual_req,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       rx_overrun
);

    localparam int IDX_W = $clog2(FRAME_IN + 1);
    localparam int K_W   = $clog2(FRAME_OUT + 1);
    localparam int T_W   = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_IN - 1);
    localparam logic [K_W-1:0]   K_LAST       = K_W'(FRAME_OUT - 1);
    localparam logic [T_W-1:0]   T_LAST       = T_W'(TIMEOUT - 1);
    localparam logic [1:0]       GUARD_CYCLES = 2'd2;

    typedef enum logic [2:0] {
        COLLECT,
        ISSUE,
        WAIT_RESULT,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [K_W-1:0]               k;
    logic [T_W-1:0]               tcnt;
    logic [1:0]                   guard;
    logic [FRAME_OUT*DBITS-1:0]   result;
    logic                         manual_q;
    logic                         manual_edge;

    assign manual_edge = manual_req && !manual_q;

    always_ff @(posedge clk) begin
        // Edge detector history is deliberately kept out of reset so a request
        // held high across reset does not look like a fresh edge afterwards.
        manual_q <= manual_req;

        if (rst) begin
            state        <= COLLECT;
            idx          <= '0;
            k            <= '0;
            tcnt         <= '0;
            guard        <= '0;
            result       <= '0;
            cp_din       <= '0;
            cp_din_valid <= 1'b0;
            tx_byte      <= '0;
            tx_send      <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            cp_din_valid <= 1'b0;
            tx_send      <= 1'b0;

            if (rx_valid && state != COLLECT) begin
                rx_overrun <= 1'b1;
            end

            case (state)
                COLLECT: begin
                    // rx_valid takes priority: a coincident manual edge is dropped.
                    if (rx_valid) begin
                        for (int i = 0; i < FRAME_IN; i++) begin
                            if (idx == IDX_W'(i)) begin
                                cp_din[i*DBITS +: DBITS] <= rx_byte;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            idx          <= '0;
                            state        <= ISSUE;
                            cp_din_valid <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (manual_edge && idx == '0) begin
                        k     <= '0;
                        state <= TX_LOAD;
                        busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT_RESULT;
                end

                WAIT_RESULT: begin
                    // A result arriving on the expiry cycle still counts.
                    if (cp_dout_valid) begin
                        result <= cp_dout;
                        k      <= '0;
                        state  <= TX_LOAD;
                    end else if (tcnt == T_LAST) begin
                        timeout_err <= 1'b1;
                        idx         <= '0;
                        state       <= COLLECT;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                TX_LOAD: begin
                    if (!tx_busy) begin
                        for (int j = 0; j < FRAME_OUT; j++) begin
                            if (k == K_W'(j)) begin
                                tx_byte <= result[j*DBITS +: DBITS];
                            end
                        end
                        tx_send <= 1'b1;
                        guard   <= '0;
                        state   <= TX_WAIT;
                    end
                end

                TX_WAIT: begin
                    // Guard cycles give the transmitter time to raise tx_busy
                    // before its level is trusted.
                    if (guard != GUARD_CYCLES) begin
                        guard <= guard + 1'b1;
                    end else if (!tx_busy) begin
                        if (k == K_LAST) begin
                            idx   <= '0;
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end else begin
                            k     <= k + 1'b1;
                            state <= TX_LOAD;
                        end
                    end
                end

                default: begin
                    idx   <= '0;
                    state <= COLLECT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Purpose: exercises uart_frame_sequencer with directed and random frames against a
//          transaction-level model (expected frames, expected tx byte stream, sticky flags).
// Latency/backpressure: drives tx_busy like a UART and cp_dout like a coprocessor.
module tb_uart_frame_sequencer;

    localparam int DBITS = 8;
    localparam int FIN   = 4;
    localparam int FOUT  = 4;
    localparam int TMO   = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DBITS-1:0]      rx_byte;
    logic                  rx_valid;
    logic [FIN*DBITS-1:0]  cp_din;
    logic                  cp_din_valid;
    logic [FOUT*DBITS-1:0] cp_dout;
    logic                  cp_dout_valid;
    logic [DBITS-1:0]      tx_byte;
    logic                  tx_send;
    logic                  tx_busy;
    logic                  manual_req;
    logic                  busy;
    logic                  timeout_err;
    logic                  rx_overrun;

    always #5 clk = ~clk;

    uart_frame_sequencer #(
        .DBITS(DBITS), .FRAME_IN(FIN), .FRAME_OUT(FOUT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .cp_din(cp_din), .cp_din_valid(cp_din_valid),
        .cp_dout(cp_dout), .cp_dout_valid(cp_dout_valid),
        .tx_byte(tx_byte), .tx_send(tx_send), .tx_busy(tx_busy),
        .manual_req(manual_req), .busy(busy),
        .timeout_err(timeout_err), .rx_overrun(rx_overrun)
    );

    // ---------------- model state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_frames[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  sent_log[$];
    logic [31:0] last_result = '0;
    logic [31:0] last_frame  = '0;
    bit          exp_timeout = 1'b0;
    bit          exp_overrun = 1'b0;
    int          cp_delay    = 0;      // 0: never answer; n: answer in n-th cycle of the wait
    logic [31:0] cp_result   = '0;
    bit          cp_pending  = 1'b0;
    int          uart_len    = 10;
    bit          noise_en    = 1'b0;
    bit          prev_txbusy = 1'b0;
    bit          prev_send   = 1'b0;
    bit          prev_cdv    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_result(input logic [31:0] r);
        for (int j = 0; j < FOUT; j++) exp_tx.push_back(r[j*8 +: 8]);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cp_din_valid) begin
            check("cdv_single_pulse", 64'(prev_cdv), 64'd0);
            check("busy_at_issue", 64'(busy), 64'd1);
            if (exp_frames.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cp_din_valid: actual %0h required no issue", cp_din);
            end else begin
                check("cp_din", 64'(cp_din), 64'(exp_frames.pop_front()));
            end
        end
        if (tx_send) begin
            check("send_while_tx_busy", 64'(prev_txbusy), 64'd0);
            check("tx_send_single_pulse", 64'(prev_send), 64'd0);
            check("busy_during_tx", 64'(busy), 64'd1);
            if (exp_tx.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tx_send: actual byte %0h required no send", tx_byte);
            end else begin
                check("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
            end
            sent_log.push_back(tx_byte);
        end
        prev_txbusy = tx_busy;
        prev_send   = tx_send;
        prev_cdv    = cp_din_valid;
    end

    // ---------------- UART transmitter model ----------------
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                @(posedge clk); #2 tx_busy = 1'b1;
                repeat (uart_len) @(posedge clk);
                #2 tx_busy = 1'b0;
            end else if (noise_en && $urandom_range(0, 15) == 0) begin
                @(posedge clk); #2 tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #2 tx_busy = 1'b0;
            end
        end
    end

    // ---------------- coprocessor model ----------------
    initial begin
        int          d;
        logic [31:0] r;
        cp_dout       = '0;
        cp_dout_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (cp_din_valid && !rst) begin
                d = cp_delay;
                r = cp_result;
                // The wait lasts TMO cycles; only answers inside it are taken.
                if (d >= 1 && d <= TMO) begin
                    last_result = r;
                    push_result(r);
                end else begin
                    exp_timeout = 1'b1;
                end
                if (d >= 1) begin
                    cp_pending = 1'b1;
                    repeat (d) @(posedge clk);
                    #2 cp_dout = r; cp_dout_valid = 1'b1;
                    @(posedge clk);
                    #2 cp_dout_valid = 1'b0;
                    cp_pending = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Returns at the negedge of the issue cycle.
    task automatic send_frame(input logic [31:0] f, input int maxgap);
        exp_frames.push_back(f);
        last_frame = f;
        tick();
        for (int i = 0; i < FIN; i++) begin
            if (i > 0) repeat ($urandom_range(0, maxgap)) tick();
            send_byte(f[i*8 +: 8]);
        end
        @(negedge clk);
        check("cdv_one_cycle_after_last_rx", 64'(cp_din_valid), 64'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && !cp_pending) done = 1'b1;
        end
        check("reach_idle", 64'(done), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cp_din"},       64'(cp_din), 64'd0);
        check({tag, "_cp_din_valid"}, 64'(cp_din_valid), 64'd0);
        check({tag, "_tx_byte"},      64'(tx_byte), 64'd0);
        check({tag, "_tx_send"},      64'(tx_send), 64'd0);
        check({tag, "_busy"},         64'(busy), 64'd0);
        check({tag, "_timeout_err"},  64'(timeout_err), 64'd0);
        check({tag, "_rx_overrun"},   64'(rx_overrun), 64'd0);
    endtask

    task automatic check_stream_ddccbbaa(input string tag);
        check({tag, "_len"}, 64'(sent_log.size()), 64'd4);
        if (sent_log.size() == 4)
            check({tag, "_order"}, 64'({sent_log[3], sent_log[2], sent_log[1], sent_log[0]}),
                  64'h00000000DDCCBBAA);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] f;
        int          d;
        int          sel;
        int          n;
        bit          ov;
        bit          mw;

        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; manual_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;

        // Replay before any result: four zero bytes.
        sent_log.delete();
        tick(); manual_req = 1'b1; push_result(last_result);
        tick(); manual_req = 1'b0;
        wait_idle();
        check("replay_zero_len", 64'(sent_log.size()), 64'd4);

        // Collect/issue and result streaming with a slow transmitter.
        sent_log.delete();
        cp_delay = 5; cp_result = 32'hDDCCBBAA; uart_len = 10;
        send_frame(32'h44332211, 0);
        check("cp_din_literal", 64'(cp_din), 64'h44332211);
        wait_idle();
        check_stream_ddccbbaa("stream");
        check("busy_drops", 64'(busy), 64'd0);

        // Result on the expiry cycle wins.
        sent_log.delete();
        cp_delay = TMO; cp_result = $urandom; uart_len = 3;
        send_frame($urandom, 2);
        wait_idle();
        check("tie_no_timeout", 64'(timeout_err), 64'd0);
        check("tie_sent_len", 64'(sent_log.size()), 64'd4);

        // Overrun during TX_WAIT leaves the frame intact.
        cp_delay = 3; cp_result = 32'hDDCCBBAA; uart_len = 10;
        send_frame($urandom, 1);
        n = 0;
        for (int c = 0; c < 500 && n < 1; c++) begin
            @(negedge clk);
            if (tx_send) n++;
        end
        check("first_send_seen", 64'(n), 64'd1);
        tick(); rx_byte = 8'h5A; rx_valid = 1'b1; exp_overrun = 1'b1;
        tick(); rx_valid = 1'b0;
        wait_idle();
        check("overrun_set", 64'(rx_overrun), 64'd1);
        check("frame_unchanged", 64'(cp_din), 64'(last_frame));

        // Manual replay of the last result.
        sent_log.delete();
        tick(); manual_req = 1'b1; push_result(last_result);
        tick(); tick(); manual_req = 1'b0;
        wait_idle();
        check_stream_ddccbbaa("replay");

        // Manual edges that must be discarded: with rx at idx 0, mid-frame, during wait.
        f = $urandom; cp_delay = 4; cp_result = $urandom;
        exp_frames.push_back(f); last_frame = f;
        tick(); rx_byte = f[7:0]; rx_valid = 1'b1; manual_req = 1'b1;
        tick(); rx_valid = 1'b0; manual_req = 1'b0;
        send_byte(f[15:8]);
        manual_req = 1'b1; tick(); manual_req = 1'b0;
        send_byte(f[23:16]);
        send_byte(f[31:24]);
        @(negedge clk);
        check("cdv_after_manual_discards", 64'(cp_din_valid), 64'd1);
        tick(); manual_req = 1'b1; tick(); manual_req = 1'b0;
        wait_idle();

        // Timeout: 16 wait cycles, late answer ignored, nothing sent.
        sent_log.delete();
        cp_delay = TMO + 1; cp_result = 32'hDDCCBBAA;
        send_frame($urandom, 0);
        repeat (TMO) @(negedge clk);
        check("timeout_not_early", 64'(timeout_err), 64'd0);
        check("busy_in_last_wait", 64'(busy), 64'd1);
        @(negedge clk);
        check("timeout_after_16", 64'(timeout_err), 64'd1);
        check("idle_after_timeout", 64'(busy), 64'd0);
        wait_idle();
        check("timeout_no_send", 64'(sent_log.size()), 64'd0);

        // Reset after the second byte send.
        cp_delay = 2; cp_result = $urandom; uart_len = 4;
        send_frame($urandom, 0);
        n = 0;
        for (int c = 0; c < 500 && n < 2; c++) begin
            @(negedge clk);
            if (tx_send) n++;
        end
        check("two_sends_before_reset", 64'(n), 64'd2);
        tick(); rst = 1'b1;
        exp_tx.delete(); exp_frames.delete();
        last_result = '0; last_frame = '0; exp_timeout = 1'b0; exp_overrun = 1'b0;
        tick();
        @(negedge clk);
        check_zero("midrst");
        tick(); rst = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_send) n++;
        end
        check("no_send_after_reset", 64'(n), 64'd0);
        sent_log.delete();
        cp_delay = 3; cp_result = $urandom; uart_len = 2;
        send_frame($urandom, 1);
        wait_idle();
        check("post_reset_frame_len", 64'(sent_log.size()), 64'd4);

        // Randomised traffic.
        for (int it = 0; it < 30; it++) begin
            noise_en = ($urandom_range(0, 3) == 0);
            uart_len = $urandom_range(1, 12);
            if ($urandom_range(0, 4) == 0) begin
                tick(); manual_req = 1'b1; push_result(last_result);
                repeat ($urandom_range(1, 3)) tick();
                manual_req = 1'b0;
                wait_idle();
            end else begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0:       d = 0;
                    1:       d = TMO;
                    2:       d = TMO + $urandom_range(1, 3);
                    default: d = $urandom_range(1, TMO - 1);
                endcase
                cp_delay = d; cp_result = $urandom;
                send_frame($urandom, 3);
                ov = ($urandom_range(0, 3) == 0);
                mw = ($urandom_range(0, 3) == 0);
                if (ov || mw) begin
                    tick();
                    if (ov) begin rx_valid = 1'b1; rx_byte = $urandom; exp_overrun = 1'b1; end
                    if (mw) manual_req = 1'b1;
                    tick();
                    rx_valid = 1'b0; manual_req = 1'b0;
                end
                wait_idle();
            end
            check("rand_timeout_err", 64'(timeout_err), 64'(exp_timeout));
            check("rand_rx_overrun", 64'(rx_overrun), 64'(exp_overrun));
            check("rand_cp_din_hold", 64'(cp_din), 64'(last_frame));
        end
        noise_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
